// File: rtl/shift_register_right6_pkg.sv
// Shared constants and types for the 6-bit right-shift register.
// Stage next-state selection is expressed as an enumerated operation.
package shift_register_right6_pkg;

    localparam int unsigned SR_WIDTH = 6;
    localparam logic [SR_WIDTH-1:0] SR_RESET_VAL = 6'b000000;

    typedef enum logic [0:0] {
        OpShift = 1'b0,
        OpLoad  = 1'b1
    } sr_op_e;

    // Clear is not encoded here; it is applied directly in the stage's flop.
    function automatic sr_op_e sr_op_sel(input logic load_en);
        sr_op_e op;
        op = OpShift;
        if (load_en) begin
            op = OpLoad;
        end
        return op;
    endfunction

endpackage

// File: rtl/shift_register_right6_sr_stage.sv
// Single shift-register stage: synchronous active-low clear, then load, else shift-in.
// True and complemented outputs are both derived from the one stored bit.
module sr_stage
    import shift_register_right6_pkg::*;
(
    input  logic clk_i,
    input  logic clear_ni,
    input  logic load_i,
    input  logic preset_i,
    input  logic shift_i,
    output logic q_o,
    output logic q_n_o
);

    logic   q_d;
    logic   q_q;
    sr_op_e op;

    always_comb begin
        op  = sr_op_sel(load_i);
        q_d = shift_i;
        unique case (op)
            OpLoad:  q_d = preset_i;
            OpShift: q_d = shift_i;
            default: q_d = shift_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!clear_ni) begin
            q_q <= SR_RESET_VAL[0];
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o   = q_q;
    assign q_n_o = ~q_q;

endmodule

// File: rtl/shift_register_right6.sv
// 6-bit right-shift register built from six chained sr_stage instances.
// Serial data enters at bit 5 and leaves (discarded) from bit 0.
module shift_register_right6
    import shift_register_right6_pkg::*;
(
    input  logic                clockpulse,
    input  logic                clear,
    input  logic                serial_input,
    input  logic                preset_enable,
    input  logic [SR_WIDTH-1:0] preset,
    output logic [SR_WIDTH-1:0] signal_q,
    output logic [SR_WIDTH-1:0] signal_q_
);

    logic [SR_WIDTH-1:0] shift_in;
    logic [SR_WIDTH-1:0] stage_q;
    logic [SR_WIDTH-1:0] stage_q_n;

    // Each stage takes its neighbour above; the MSB takes the serial input.
    assign shift_in = {serial_input, stage_q[SR_WIDTH-1:1]};

    for (genvar i = 0; i < SR_WIDTH; i++) begin : g_stage
        sr_stage u_stage (
            .clk_i    (clockpulse),
            .clear_ni (clear),
            .load_i   (preset_enable),
            .preset_i (preset[i]),
            .shift_i  (shift_in[i]),
            .q_o      (stage_q[i]),
            .q_n_o    (stage_q_n[i])
        );
    end

    assign signal_q  = stage_q;
    assign signal_q_ = stage_q_n;

endmodule

// File: tb/tb_shift_register_right6.sv
// Self-checking bench for shift_register_right6 against an arithmetic reference model.
module tb_shift_register_right6;

    logic       clockpulse = 1'b0;
    logic       clear = 1'b1;
    logic       serial_input = 1'b0;
    logic       preset_enable = 1'b0;
    logic [5:0] preset = 6'd0;
    logic [5:0] signal_q;
    logic [5:0] signal_q_;

    int n_checks = 0;
    int n_fail   = 0;
    int model    = 0;

    shift_register_right6 dut (
        .clockpulse    (clockpulse),
        .clear         (clear),
        .serial_input  (serial_input),
        .preset_enable (preset_enable),
        .preset        (preset),
        .signal_q      (signal_q),
        .signal_q_     (signal_q_)
    );

    always #5 clockpulse = ~clockpulse;

    // One rising edge, then update the model from the inputs present at that edge.
    task automatic step();
        @(posedge clockpulse);
        #1;
        if (!clear) model = 0;
        else if (preset_enable) model = int'(preset);
        else model = (model >> 1) + (int'(serial_input) * 32);
    endtask

    task automatic test_reset();
        clear = 1'b0; preset_enable = 1'b1; preset = 6'b110000; serial_input = 1'b1;
        step();
        n_checks++;
        if (signal_q !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_q: got %b want 000000", signal_q);
        end
        n_checks++;
        if (signal_q_ !== 6'b111111) begin
            n_fail++;
            $display("FAIL reset_qn: got %b want 111111", signal_q_);
        end
    endtask

    task automatic test_load_drain();
        logic [5:0] table_exp [7] = '{6'b110000, 6'b011000, 6'b001100, 6'b000110,
                                      6'b000011, 6'b000001, 6'b000000};
        clear = 1'b1; preset = 6'b110000; preset_enable = 1'b1; serial_input = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            preset_enable = 1'b0;
            n_checks++;
            if (signal_q !== ((k < 7) ? table_exp[k] : 6'b000000)) begin
                n_fail++;
                $display("FAIL drain_q[%0d]: got %b want %b", k, signal_q,
                         (k < 7) ? table_exp[k] : 6'b000000);
            end
            n_checks++;
            if (signal_q_ !== ~signal_q) begin
                n_fail++;
                $display("FAIL drain_qn[%0d]: got %b want %b", k, signal_q_, ~signal_q);
            end
        end
    endtask

    task automatic test_serial_fill();
        logic [5:0] exp;
        serial_input = 1'b1; preset_enable = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp = 6'(((1 << k) - 1) << (6 - k));
            n_checks++;
            if (signal_q !== exp || int'(signal_q) !== model) begin
                n_fail++;
                $display("FAIL fill[%0d]: got %b want %b", k, signal_q, exp);
            end
        end
    endtask

    task automatic test_repeated_load();
        preset = 6'b101010; preset_enable = 1'b1; serial_input = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (signal_q !== 6'b101010) begin
                n_fail++;
                $display("FAIL reload[%0d]: got %b want 101010", k, signal_q);
            end
        end
        preset_enable = 1'b0;
    endtask

    task automatic test_mid_clear();
        preset = 6'b111111; preset_enable = 1'b1; serial_input = 1'b0;
        step();
        preset_enable = 1'b0;
        step();
        step();
        n_checks++;
        if (signal_q !== 6'b001111) begin
            n_fail++;
            $display("FAIL mid_shift: got %b want 001111", signal_q);
        end
        // Clear pulse entirely between edges must be ignored.
        #2 clear = 1'b0;
        #2 clear = 1'b1;
        n_checks++;
        if (signal_q !== 6'b001111) begin
            n_fail++;
            $display("FAIL clear_between_edges: got %b want 001111", signal_q);
        end
        step();
        n_checks++;
        if (signal_q !== 6'b000111) begin
            n_fail++;
            $display("FAIL after_glitch_clear: got %b want 000111", signal_q);
        end
        clear = 1'b0;
        step();
        clear = 1'b1;
        n_checks++;
        if (signal_q !== 6'b000000 || signal_q_ !== 6'b111111) begin
            n_fail++;
            $display("FAIL mid_clear: got %b/%b want 000000/111111", signal_q, signal_q_);
        end
    endtask

    task automatic test_glitch();
        logic [5:0] held;
        preset = 6'b100101; preset_enable = 1'b1;
        step();
        preset_enable = 1'b0; serial_input = 1'b1;
        for (int c = 0; c < 4; c++) begin
            held = signal_q;
            for (int t = 0; t < 6; t++) begin
                #1;
                preset = 6'($urandom);
                serial_input = ~serial_input;
                preset_enable = ~preset_enable;
                n_checks++;
                if (signal_q !== held) begin
                    n_fail++;
                    $display("FAIL glitch[%0d.%0d]: got %b want %b", c, t, signal_q, held);
                end
            end
            preset_enable = 1'b0; serial_input = 1'($urandom);
            step();
            n_checks++;
            if (int'(signal_q) !== model) begin
                n_fail++;
                $display("FAIL glitch_edge[%0d]: got %b want %b", c, signal_q, 6'(model));
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            clear         = ($urandom_range(0, 7) != 0);
            preset_enable = ($urandom_range(0, 3) == 0);
            preset        = 6'($urandom);
            serial_input  = 1'($urandom);
            step();
            n_checks++;
            if (int'(signal_q) !== model || signal_q_ !== ~signal_q) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b/%b want %b", k, signal_q, signal_q_,
                         6'(model));
            end
        end
        clear = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        test_load_drain();
        test_serial_fill();
        test_repeated_load();
        test_mid_clear();
        test_glitch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_register_right6.md
# shift_register_right6

- 6-bit right-shift register with serial input, synchronous parallel preset and synchronous active-low clear.
- Drives true and complemented outputs for every stage.
- Used as a clocked datapath/lab building block where a preset pattern is loaded, then shifted toward bit 0 while zeros (or any serial bit) enter at bit 5.
- Implemented as six identical flip-flop stages with per-stage next-state selection.

## Interface

Parameters:
- none; width fixed at 6 bits.

Ports:
- `clockpulse`  in  1  clock; all state changes on its rising edge only.
- `clear`  in  1  reset; synchronous and active-low: `clear`=0 at a rising edge of `clockpulse` clears all stages.
- `serial_input`  in  1  bit shifted into stage 5 (MSB) on each shift.
- `preset_enable`  in  1  synchronous parallel-load enable, active-high.
- `preset`  in  6  parallel-load value.
- `signal_q`  out  6  register contents; bit 5 = MSB / serial entry end, bit 0 = shift-out end.
- `signal_q_`  out  6  bitwise complement of `signal_q`.

## Operation

At each rising edge of `clockpulse`, priority is fixed as:

- **Clear:**
  - Condition: `clear`=0.
  - Effect: `signal_q` ← 6'b000000.
- **Load:**
  - Condition: else if `preset_enable`=1.
  - Effect: `signal_q` ← `preset`.
- **Shift right:**
  - Condition: else.
  - Effect: `signal_q[5]` ← `serial_input`; `signal_q[i]` ← `signal_q[i+1]` for i=4..0.
  - The old `signal_q[0]` is discarded.

Output and state rules:
- `signal_q_` is always exactly `~signal_q`, both derived from the same stored state; no separately stored complement.
- Reset value: `signal_q`=6'b000000, `signal_q_`=6'b111111.
- No hold mode: every non-clear, non-load edge shifts.
- With `serial_input`=0, a loaded pattern drains to zero after at most 6 shifts and stays zero.

## Timing

- All inputs are sampled only at the rising edge of `clockpulse`; one-edge latency to outputs.
- Outputs change only after a rising edge; between edges they are stable regardless of input activity.
- `clear` is synchronous: asserting or deasserting it between edges has no effect until the next rising edge.
- Before the first clearing edge, contents are undefined.
- Simultaneous `clear`=0 and `preset_enable`=1: clear wins.
- `preset_enable` is level-sampled: held high for N edges, it reloads `preset` N times, so no shifting occurs.
- Reset mid-shift: the next edge with `clear`=0 zeroes all stages regardless of the current pattern.

## Structure

- Shared package holds:
  - width constant `SR_WIDTH`=6.
  - reset value constant 6'b000000.
- Natural sub-module: `sr_stage`, a single stage instantiated 6 times and chained MSB→LSB. Each instance has:
  - inputs: clock, active-low sync clear, load enable, preset bit, shift-in bit;
  - outputs: `q`, `q_`.
- Top level:
  - wires `serial_input` to stage 5's shift-in;
  - wires stage i+1's `q` to stage i's shift-in;
  - concatenates the stage outputs into `signal_q` / `signal_q_`.

## Test plan

- Reset:
  - Stimulus: `clear`=0 for one rising edge, with `preset_enable`=1 and `preset`=6'b110000.
  - Required: `signal_q`=000000, `signal_q_`=111111 (clear overrides load).
- Load then drain:
  - Stimulus: `clear`=1, `preset`=6'b110000, `preset_enable`=1 for one edge, then 0; `serial_input`=0.
  - Required `signal_q` on successive edges: 110000, 011000, 001100, 000110, 000011, 000001, 000000.
  - Required afterwards: stays 000000 over the remaining edges of a 15-edge run.
  - `signal_q_` is the complement at every step.
- Serial fill:
  - Stimulus: from 000000 with `serial_input`=1.
  - Required over 6 edges: 100000, 110000, 111000, 111100, 111110, 111111.
- Repeated load:
  - Stimulus: `preset_enable` held high for 3 edges with `preset`=6'b101010.
  - Required: `signal_q`=101010 after each of those edges, with no shifting.
- Mid-operation clear:
  - Stimulus: load 6'b111111, shift 2 edges (expect 001111 with `serial_input`=0), then `clear`=0 for one edge.
  - Required: 000000.
  - Also check that a `clear` pulse to 0 entirely between edges has no effect.
- Input glitch immunity:
  - Stimulus: toggle `preset`, `serial_input` and `preset_enable` between rising edges.
  - Required: `signal_q` changes only at rising edges.
